// File: rtl/pong_ball_ctrl.sv
// pong_ball_ctrl -- ball controller for Socially Distanced Pong.
//
// Moves the ball one step per game tick. It bounces the ball off the
// top/bottom walls and both paddles, detects misses and awards points. It also
// runs the serve countdown and ends the match at MAX_SCORE.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   tick              one-clk game-rate step enable
//   start             begin / restart a match (acts in IDLE and GAME_OVER)
//   left_paddle_y     left paddle top edge
//   right_paddle_y    right paddle top edge
//   ball_x, ball_y    ball top-left corner
//   score_left/right  player scores
//   point_scored      one-clk pulse when a point is awarded
//   scorer            1 = left scored, 0 = right scored (held until next point)
//   game_over         high while the match is over
//
// Build option: define PONG_SPEEDUP_EN to speed the ball up by one pixel per
// tick every 4 paddle hits, capped at MAX_STEP. Without it the step is STEP.
module pong_ball_ctrl #(
  parameter int WIDTH          = 10,
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int BALL_SIZE      = 4,
  parameter int PADDLE_W       = 4,
  parameter int PADDLE_H       = 48,
  parameter int LEFT_PADDLE_X  = 16,
  parameter int RIGHT_PADDLE_X = 620,
  parameter int STEP           = 2,
  parameter int MAX_STEP       = 5,
  parameter int SERVE_DELAY    = 24,
  parameter int MAX_SCORE      = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic [WIDTH-1:0] left_paddle_y,
  input  logic [WIDTH-1:0] right_paddle_y,
  output logic [WIDTH-1:0] ball_x,
  output logic [WIDTH-1:0] ball_y,
  output logic [3:0]       score_left,
  output logic [3:0]       score_right,
  output logic             point_scored,
  output logic             scorer,
  output logic             game_over
);

  typedef enum logic [2:0] {S_IDLE, S_SERVE, S_MOVE, S_SCORED, S_GAME_OVER} state_t;
  typedef logic [WIDTH-1:0] coord_t;
  // One extra bit so sums of coordinates never wrap in comparisons.
  typedef logic [WIDTH:0]   wide_t;

  localparam int STEP_TOP = (STEP > MAX_STEP) ? STEP : MAX_STEP;
  localparam int STEP_W   = $clog2(STEP_TOP + 1);
  typedef logic [STEP_W-1:0] step_t;

  localparam int CNT_W = $clog2(SERVE_DELAY + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t SERVE_LOAD = cnt_t'(SERVE_DELAY - 1);

  localparam coord_t CENTER_X = coord_t'(SCREEN_W/2 - BALL_SIZE/2);
  localparam coord_t CENTER_Y = coord_t'(SCREEN_H/2 - BALL_SIZE/2);
  localparam coord_t LF_X     = coord_t'(LEFT_PADDLE_X + PADDLE_W);
  localparam coord_t RF_X     = coord_t'(RIGHT_PADDLE_X - BALL_SIZE);
  localparam coord_t X_MAX    = coord_t'(SCREEN_W - BALL_SIZE);
  localparam coord_t Y_MAX    = coord_t'(SCREEN_H - BALL_SIZE);
  localparam wide_t  W_LF     = wide_t'(LEFT_PADDLE_X + PADDLE_W);
  localparam wide_t  W_RF     = wide_t'(RIGHT_PADDLE_X - BALL_SIZE);
  localparam wide_t  W_XMAX   = wide_t'(SCREEN_W - BALL_SIZE);
  localparam wide_t  W_SH     = wide_t'(SCREEN_H);
  localparam wide_t  W_BS     = wide_t'(BALL_SIZE);
  localparam wide_t  W_PH     = wide_t'(PADDLE_H);

  state_t state_q, state_d;
  coord_t ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic [3:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic point_q, point_d, scorer_q, scorer_d, over_q, over_d;
  logic dir_right_q, dir_right_d, dir_down_q, dir_down_d;
  cnt_t serve_cnt_q, serve_cnt_d;
  step_t step;

`ifdef PONG_SPEEDUP_EN
  step_t step_q, step_d;
  logic [1:0] hit_cnt_q, hit_cnt_d;
  assign step = step_q;
`else
  assign step = step_t'(STEP);
`endif

  // Per-tick motion, computed from the pre-tick position.
  wide_t  bx, by, st, lpy, rpy;
  coord_t x_mv, y_mv;
  logic   dr_mv, dd_mv, hit, miss, ovl_l, ovl_r, left_wins;
  logic [3:0] win_score;

  always_comb begin
    bx    = {1'b0, ball_x_q};
    by    = {1'b0, ball_y_q};
    st    = wide_t'(step);
    lpy   = {1'b0, left_paddle_y};
    rpy   = {1'b0, right_paddle_y};
    ovl_l = (by + W_BS > lpy) && (by < lpy + W_PH);
    ovl_r = (by + W_BS > rpy) && (by < rpy + W_PH);
    x_mv  = ball_x_q;
    y_mv  = ball_y_q;
    dr_mv = dir_right_q;
    dd_mv = dir_down_q;
    hit   = 1'b0;
    miss  = 1'b0;

    if (dir_down_q) begin
      if (by + st + W_BS >= W_SH) begin
        y_mv  = Y_MAX;
        dd_mv = 1'b0;
      end else y_mv = ball_y_q + coord_t'(step);
    end else begin
      if (by < st) begin
        y_mv  = '0;
        dd_mv = 1'b1;
      end else y_mv = ball_y_q - coord_t'(step);
    end

    // Paddle hit is tested before the miss so a grazing hit near the edge wins.
    if (!dir_right_q) begin
      if (bx >= W_LF && bx <= W_LF + st && ovl_l) begin
        x_mv  = LF_X;
        dr_mv = 1'b1;
        hit   = 1'b1;
      end else if (bx < st) begin
        x_mv = '0;
        miss = 1'b1;
      end else x_mv = ball_x_q - coord_t'(step);
    end else begin
      if (bx <= W_RF && bx + st >= W_RF && ovl_r) begin
        x_mv  = RF_X;
        dr_mv = 1'b0;
        hit   = 1'b1;
      end else if (bx + st > W_XMAX) begin
        x_mv = X_MAX;
        miss = 1'b1;
      end else x_mv = ball_x_q + coord_t'(step);
    end

    // In SCORED the ball still sits at the wall it missed at: x = 0 means the
    // left player missed, so the right player scored.
    left_wins = (ball_x_q != '0);
    win_score = left_wins ? score_l_q + 4'd1 : score_r_q + 4'd1;
  end

  // State register
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start) state_d = S_SERVE;
      S_SERVE:     if (tick && serve_cnt_q == '0) state_d = S_MOVE;
      S_MOVE:      if (tick && miss) state_d = S_SCORED;
      S_SCORED:    state_d = (win_score == 4'(MAX_SCORE)) ? S_GAME_OVER : S_SERVE;
      S_GAME_OVER: if (start) state_d = S_SERVE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Outputs and datapath
  always_comb begin
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    point_d     = 1'b0;
    scorer_d    = scorer_q;
    over_d      = (state_d == S_GAME_OVER);
    dir_right_d = dir_right_q;
    dir_down_d  = dir_down_q;
    serve_cnt_d = serve_cnt_q;
`ifdef PONG_SPEEDUP_EN
    step_d      = step_q;
    hit_cnt_d   = hit_cnt_q;
`endif

    if (state_d == S_SERVE && state_q != S_SERVE)
      serve_cnt_d = SERVE_LOAD;
    else if (state_q == S_SERVE && tick && serve_cnt_q != '0)
      serve_cnt_d = serve_cnt_q - cnt_t'(1);

    case (state_q)
      S_MOVE: if (tick) begin
        ball_x_d    = x_mv;
        ball_y_d    = y_mv;
        dir_right_d = dr_mv;
        dir_down_d  = dd_mv;
`ifdef PONG_SPEEDUP_EN
        if (hit) begin
          hit_cnt_d = hit_cnt_q + 2'd1;
          if (hit_cnt_q == 2'd3 && step_q < step_t'(MAX_STEP))
            step_d = step_q + step_t'(1);
        end
`endif
      end
      S_SCORED: begin
        if (left_wins) score_l_d = win_score;
        else           score_r_d = win_score;
        point_d     = 1'b1;
        scorer_d    = left_wins;
        ball_x_d    = CENTER_X;
        ball_y_d    = CENTER_Y;
        dir_right_d = left_wins;   // serve toward the player who lost the point
`ifdef PONG_SPEEDUP_EN
        step_d      = step_t'(STEP);
        hit_cnt_d   = '0;
`endif
      end
      S_GAME_OVER: if (start) begin
        score_l_d = '0;
        score_r_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ball_x_q    <= CENTER_X;
      ball_y_q    <= CENTER_Y;
      score_l_q   <= '0;
      score_r_q   <= '0;
      point_q     <= 1'b0;
      scorer_q    <= 1'b0;
      over_q      <= 1'b0;
      dir_right_q <= 1'b1;
      dir_down_q  <= 1'b1;
      serve_cnt_q <= '0;
`ifdef PONG_SPEEDUP_EN
      step_q      <= step_t'(STEP);
      hit_cnt_q   <= '0;
`endif
    end else begin
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      point_q     <= point_d;
      scorer_q    <= scorer_d;
      over_q      <= over_d;
      dir_right_q <= dir_right_d;
      dir_down_q  <= dir_down_d;
      serve_cnt_q <= serve_cnt_d;
`ifdef PONG_SPEEDUP_EN
      step_q      <= step_d;
      hit_cnt_q   <= hit_cnt_d;
`endif
    end
  end

  assign ball_x       = ball_x_q;
  assign ball_y       = ball_y_q;
  assign score_left   = score_l_q;
  assign score_right  = score_r_q;
  assign point_scored = point_q;
  assign scorer       = scorer_q;
  assign game_over    = over_q;

endmodule
